// File: rtl/cp0_irq_pkg.sv
// Shared constants for the CP0 interrupt/timer unit: register map, source layout
// and a constant-evaluable clog2 for sizing the interrupt id.
package cp0_irq_pkg;

   localparam logic [3:0] A_SOFT  = 4'd0;
   localparam logic [3:0] A_MODE  = 4'd1;
   localparam logic [3:0] A_PEND  = 4'd2;
   localparam logic [3:0] A_COUNT = 4'd3;
   localparam logic [3:0] A_CMP0  = 4'd4;

   localparam int unsigned N_SOFT   = 2;
   localparam int unsigned SRC_SOFT = 0;
   localparam int unsigned SRC_EXT  = 2;

   // Never returns less than 1 so a single-source id still has a bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/cp0_irq_timer_if.sv
// Register bus plus interrupt inputs/outputs between the CP0 complex and the irq/timer unit.
interface cp0_irq_timer_if
   import cp0_irq_pkg::*;
#(
   parameter int unsigned N_EXT   = 5,
   parameter int unsigned N_TIMER = 2
);
   localparam int unsigned N_SRC = N_SOFT + N_EXT + N_TIMER;
   localparam int unsigned ID_W  = clog2(N_SRC);

   logic              stall;
   logic              we;
   logic [3:0]        addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic [N_EXT-1:0]  irq_ext;
   logic [N_SRC-1:0]  im;
   logic              status_ie;
   logic              status_exl;
   logic              status_erl;
   logic              exc_accept;
   logic              eret;
   logic              irq;
   logic [ID_W-1:0]   irq_id;
   logic [N_SRC-1:0]  pend;

   modport master (
      output stall, we, addr, wdata, irq_ext, im, status_ie, status_exl, status_erl,
             exc_accept, eret,
      input  rdata, irq, irq_id, pend
   );

   modport slave (
      input  stall, we, addr, wdata, irq_ext, im, status_ie, status_exl, status_erl,
             exc_accept, eret,
      output rdata, irq, irq_id, pend
   );

endinterface

// File: rtl/cp0_irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line with rising-edge detect
// on the synchronised level.
module cp0_irq_sync_edge #(
   parameter int unsigned SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_c_o
);
   logic [SYNC_STG-1:0] sync_q;
   logic                prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], d_i};
         prev_q <= sync_q[SYNC_STG-1];
      end
   end

   assign lvl_o    = sync_q[SYNC_STG-1];
   assign rise_c_o = sync_q[SYNC_STG-1] & ~prev_q;

endmodule

// File: rtl/cp0_irq_timer.sv
// CP0 interrupt/timer unit: shared Count with N_TIMER compares, synchronised external
// lines, two software IRQs, sticky pending capture and the prioritised gated request.
module cp0_irq_timer
   import cp0_irq_pkg::*;
#(
   parameter int unsigned N_EXT    = 5,
   parameter int unsigned N_TIMER  = 2,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   cp0_irq_timer_if.slave bus
);
   localparam int unsigned N_SRC   = N_SOFT + N_EXT + N_TIMER;
   localparam int unsigned ID_W    = clog2(N_SRC);
   localparam int unsigned SRC_TMR = SRC_EXT + N_EXT;

   logic [CNT_W-1:0]              count_q, count_d;
   logic [N_TIMER-1:0][CNT_W-1:0] cmp_q, cmp_d;
   logic [N_SOFT-1:0]             soft_q, soft_d;
   logic [N_EXT-1:0]              mode_q, mode_d;
   logic [N_EXT-1:0]              ext_stk_q, ext_stk_d;
   logic [N_EXT-1:0]              ext_lvl, ext_rise;
   logic [N_TIMER-1:0]            tmr_q, tmr_d, hit_c;
   logic [31:0]                   rdata_q, rdata_d;
   logic [N_SRC-1:0]              pend_c, act_c, clr_c;
   logic                          irq_c, wr_c;
   logic [ID_W-1:0]               id_c;

   for (genvar i = 0; i < N_EXT; i++) begin : g_ext
      cp0_irq_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
         .clk      (clk),
         .rst_n    (rst_n),
         .d_i      (bus.irq_ext[i]),
         .lvl_o    (ext_lvl[i]),
         .rise_c_o (ext_rise[i])
      );
   end

   assign wr_c = bus.we & ~bus.stall;

   // Pending view, gating and highest-index-wins encoder.
   always_comb begin
      pend_c                      = '0;
      pend_c[SRC_SOFT +: N_SOFT]  = soft_q;
      pend_c[SRC_EXT  +: N_EXT]   = (mode_q & ext_stk_q) | (~mode_q & ext_lvl);
      pend_c[SRC_TMR  +: N_TIMER] = tmr_q;
      act_c = pend_c & bus.im;
      irq_c = (|act_c) & bus.status_ie & ~bus.status_exl & ~bus.status_erl;
      id_c  = '0;
      for (int unsigned s = 0; s < N_SRC; s++) begin
         if (act_c[s]) id_c = ID_W'(s);
      end
      if (!irq_c) id_c = '0;
   end

   // Register writes and sticky capture; set events beat ack/W1C, compare/mode writes beat sets.
   always_comb begin
      count_d   = count_q + CNT_W'(1);
      cmp_d     = cmp_q;
      soft_d    = soft_q;
      mode_d    = mode_q;
      clr_c     = '0;
      for (int unsigned k = 0; k < N_TIMER; k++) begin
         hit_c[k] = (count_q == cmp_q[k]);
      end
      if (bus.exc_accept && irq_c) clr_c = N_SRC'(1) << id_c;
      if (wr_c && bus.addr == A_PEND) clr_c = clr_c | bus.wdata[N_SRC-1:0];
      ext_stk_d = (ext_stk_q & ~clr_c[SRC_EXT +: N_EXT]) | (ext_rise & mode_q);
      tmr_d     = (tmr_q & ~clr_c[SRC_TMR +: N_TIMER]) | hit_c;
      if (wr_c) begin
         if (bus.addr == A_SOFT)  soft_d  = bus.wdata[N_SOFT-1:0];
         if (bus.addr == A_MODE)  mode_d  = bus.wdata[N_EXT-1:0];
         if (bus.addr == A_COUNT) count_d = bus.wdata[CNT_W-1:0];
         for (int unsigned k = 0; k < N_TIMER; k++) begin
            if (bus.addr == A_CMP0 + 4'(k)) begin
               cmp_d[k] = bus.wdata[CNT_W-1:0];
               tmr_d[k] = 1'b0;
            end
         end
      end
      ext_stk_d = ext_stk_d & ~(mode_d ^ mode_q);
      if (bus.eret) soft_d = '0;
   end

   // Read mux; holds while stalled.
   always_comb begin
      rdata_d = rdata_q;
      if (!bus.stall) begin
         rdata_d = '0;
         if (bus.addr == A_SOFT)  rdata_d = 32'(soft_q);
         if (bus.addr == A_MODE)  rdata_d = 32'(mode_q);
         if (bus.addr == A_PEND)  rdata_d = 32'(pend_c);
         if (bus.addr == A_COUNT) rdata_d = 32'(count_q);
         for (int unsigned k = 0; k < N_TIMER; k++) begin
            if (bus.addr == A_CMP0 + 4'(k)) rdata_d = 32'(cmp_q[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         cmp_q     <= '1;
         soft_q    <= '0;
         mode_q    <= '0;
         ext_stk_q <= '0;
         tmr_q     <= '0;
         rdata_q   <= '0;
      end else begin
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         soft_q    <= soft_d;
         mode_q    <= mode_d;
         ext_stk_q <= ext_stk_d;
         tmr_q     <= tmr_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.irq    = irq_c;
   assign bus.irq_id = id_c;
   assign bus.pend   = pend_c;

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Scoreboard bench for cp0_irq_timer: a behavioural model predicts pend/irq/irq_id/rdata
// every cycle; a monitor pops and compares at mid-cycle.
module tb_cp0_irq_timer;
   import cp0_irq_pkg::*;

   localparam int N_EXT    = 5;
   localparam int N_TIMER  = 2;
   localparam int CNT_W    = 32;
   localparam int SYNC_STG = 2;
   localparam int N_SRC    = 2 + N_EXT + N_TIMER;
   localparam int ID_W     = int'(clog2(N_SRC));

   typedef struct packed {
      logic [N_SRC-1:0] pend;
      logic             irq;
      logic [ID_W-1:0]  id;
      logic [31:0]      rdata;
   } exp_t;

   logic clk;
   logic rst_n;
   cp0_irq_timer_if #(.N_EXT(N_EXT), .N_TIMER(N_TIMER)) bus ();

   cp0_irq_timer #(.N_EXT(N_EXT), .N_TIMER(N_TIMER), .CNT_W(CNT_W), .SYNC_STG(SYNC_STG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   // Reference model state
   bit [31:0] m_count;
   bit [31:0] m_cmp   [N_TIMER];
   bit [1:0]  m_soft;
   bit        m_mode  [N_EXT];
   bit        m_stk   [N_SRC];
   bit        m_pin   [N_EXT][SYNC_STG+1];
   bit [31:0] m_rdata;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", nm, $time, act, exp);
   endfunction

   function automatic void m_reset();
      m_count = 0;
      m_soft  = 0;
      m_rdata = 0;
      for (int k = 0; k < N_TIMER; k++) m_cmp[k] = 32'hFFFF_FFFF;
      for (int s = 0; s < N_SRC; s++) m_stk[s] = 0;
      for (int i = 0; i < N_EXT; i++) begin
         m_mode[i] = 0;
         for (int j = 0; j <= SYNC_STG; j++) m_pin[i][j] = 0;
      end
   endfunction

   function automatic bit m_pend(int s);
      if (s < 2) return m_soft[s];
      if (s < 2 + N_EXT) return m_mode[s-2] ? m_stk[s] : m_pin[s-2][SYNC_STG-1];
      return m_stk[s];
   endfunction

   function automatic bit [31:0] m_read(int a);
      bit [31:0] v;
      v = 0;
      if (a == 0) v = 32'(m_soft);
      else if (a == 1) begin
         for (int i = 0; i < N_EXT; i++) v[i] = m_mode[i];
      end else if (a == 2) begin
         for (int s = 0; s < N_SRC; s++) v[s] = m_pend(s);
      end else if (a == 3) v = m_count;
      else if (a >= 4 && a < 4 + N_TIMER) v = m_cmp[a-4];
      return v;
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      int   top;
      top = -1;
      e   = '0;
      for (int s = 0; s < N_SRC; s++) begin
         e.pend[s] = m_pend(s);
         if (e.pend[s] && bus.im[s]) top = s;
      end
      e.irq   = (top >= 0) && bus.status_ie && !bus.status_exl && !bus.status_erl;
      e.id    = e.irq ? ID_W'(top) : '0;
      e.rdata = m_rdata;
      return e;
   endfunction

   // One clock edge of the model, from the inputs currently applied.
   function automatic void m_edge(bit irq, int id);
      bit        wr;
      int        a;
      bit        nstk [N_SRC];
      bit [31:0] nrd;
      wr  = bus.we && !bus.stall;
      a   = int'(bus.addr);
      nrd = bus.stall ? m_rdata : m_read(a);
      nstk[0] = 0;
      nstk[1] = 0;
      for (int s = 2; s < N_SRC; s++) begin
         bit set, clr;
         if (s < 2 + N_EXT) set = m_mode[s-2] && m_pin[s-2][SYNC_STG-1] && !m_pin[s-2][SYNC_STG];
         else set = (m_count == m_cmp[s-2-N_EXT]);
         clr = (bus.exc_accept && irq && id == s) || (wr && a == 2 && bus.wdata[s]);
         nstk[s] = set || (m_stk[s] && !clr);
      end
      if (wr && a == 0) m_soft = bus.wdata[1:0];
      if (wr && a == 1) begin
         for (int i = 0; i < N_EXT; i++) begin
            if (m_mode[i] != bus.wdata[i]) nstk[2+i] = 0;
            m_mode[i] = bus.wdata[i];
         end
      end
      if (wr && a >= 4 && a < 4 + N_TIMER) begin
         m_cmp[a-4]          = bus.wdata;
         nstk[2+N_EXT+a-4]   = 0;
      end
      if (bus.eret) m_soft = 0;
      m_count = (wr && a == 3) ? bus.wdata : m_count + 32'd1;
      for (int i = 0; i < N_EXT; i++) begin
         for (int j = SYNC_STG; j > 0; j--) m_pin[i][j] = m_pin[i][j-1];
         m_pin[i][0] = bus.irq_ext[i];
      end
      for (int s = 0; s < N_SRC; s++) m_stk[s] = nstk[s];
      m_rdata = nrd;
   endfunction

   // Called just after a falling edge with this cycle's inputs applied.
   task automatic tick();
      exp_t e;
      if (!rst_n) m_reset();
      e = m_expect();
      exp_q.push_back(e);
      if (rst_n) m_edge(e.irq, int'(e.id));
      @(negedge clk);
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic wr_reg(int a, bit [31:0] d);
      bus.we    = 1'b1;
      bus.addr  = 4'(a);
      bus.wdata = d;
      tick();
      bus.we    = 1'b0;
   endtask

   task automatic rd_reg(int a);
      bus.addr = 4'(a);
      tick();
   endtask

   // Monitor: compare DUT outputs against the queued prediction mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pend",   32'(bus.pend),   32'(e.pend));
            chk("irq",    32'(bus.irq),    32'(e.irq));
            chk("irq_id", 32'(bus.irq_id), 32'(e.id));
            chk("rdata",  bus.rdata,       e.rdata);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int        a;
      int        k;
      bit [31:0] d;
      rst_n          = 1'b0;
      bus.stall      = 1'b0;
      bus.we         = 1'b0;
      bus.addr       = '0;
      bus.wdata      = '0;
      bus.irq_ext    = '0;
      bus.im         = '1;
      bus.status_ie  = 1'b1;
      bus.status_exl = 1'b0;
      bus.status_erl = 1'b0;
      bus.exc_accept = 1'b0;
      bus.eret       = 1'b0;
      m_reset();
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;

      // Reset mid-count
      idle(8);
      rd_reg(3);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      rd_reg(3);
      rd_reg(4);
      idle(2);

      // Timer 1 hit, then cleared by compare write
      wr_reg(5, 32'h14);
      wr_reg(3, 32'h10);
      rd_reg(2);
      idle(5);
      wr_reg(5, 32'hFFFF_FFFF);
      idle(2);

      // Edge-mode line 0: capture, ack, then pulse landing on the ack cycle
      wr_reg(1, 32'h1);
      bus.irq_ext[0] = 1'b1;
      tick();
      bus.irq_ext[0] = 1'b0;
      idle(4);
      bus.exc_accept = 1'b1;
      tick();
      bus.exc_accept = 1'b0;
      idle(2);
      bus.irq_ext[0] = 1'b1;
      tick();
      bus.irq_ext[0] = 1'b0;
      idle(4);
      bus.irq_ext[0] = 1'b1;
      tick();
      bus.irq_ext[0] = 1'b0;
      tick();
      bus.exc_accept = 1'b1;
      tick();
      bus.exc_accept = 1'b0;
      idle(3);

      // Level line 3 with SOFT=01, then eret
      wr_reg(1, 32'h0);
      wr_reg(0, 32'h1);
      bus.irq_ext[3] = 1'b1;
      idle(4);
      bus.irq_ext[3] = 1'b0;
      idle(3);
      bus.eret = 1'b1;
      wr_reg(0, 32'h3);
      bus.eret = 1'b0;
      rd_reg(0);
      idle(1);

      // EXL gating, stalled write and held rdata
      wr_reg(0, 32'h2);
      bus.status_exl = 1'b1;
      idle(3);
      bus.status_exl = 1'b0;
      rd_reg(0);
      bus.stall = 1'b1;
      wr_reg(3, 32'h0);
      rd_reg(3);
      bus.stall = 1'b0;
      rd_reg(3);
      idle(1);

      // Wrap, hit at zero, W1C, compare write racing a hit, unmapped addresses
      wr_reg(4, 32'h0);
      wr_reg(3, 32'hFFFF_FFFF);
      idle(3);
      wr_reg(1, 32'h1);
      bus.irq_ext[0] = 1'b1;
      idle(4);
      bus.irq_ext[0] = 1'b0;
      rd_reg(2);
      wr_reg(2, 32'hFFFF);
      rd_reg(2);
      rd_reg(1);
      wr_reg(4, 32'h200);
      wr_reg(3, 32'h1FE);
      idle(2);
      wr_reg(4, 32'h300);
      wr_reg(9, 32'h1234);
      rd_reg(7);
      rd_reg(15);
      idle(2);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         bus.stall      = ($urandom_range(0, 99) < 15);
         bus.we         = ($urandom_range(0, 99) < 35);
         a              = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
         bus.addr       = 4'(a);
         k              = int'($urandom_range(0, 2));
         if (a == 3) d = (k == 0) ? 32'hFFFF_FFFF :
                         (k == 1) ? m_cmp[$urandom_range(0, N_TIMER-1)] - $urandom_range(0, 6) : $urandom;
         else if (a == 4 || a == 5) d = m_count + $urandom_range(0, 12);
         else d = $urandom;
         bus.wdata      = d;
         for (int i = 0; i < N_EXT; i++) begin
            if ($urandom_range(0, 9) == 0) bus.irq_ext[i] = ~bus.irq_ext[i];
         end
         bus.im         = N_SRC'($urandom | $urandom);
         bus.status_ie  = ($urandom_range(0, 9) != 0);
         bus.status_exl = ($urandom_range(0, 19) == 0);
         bus.status_erl = ($urandom_range(0, 19) == 0);
         bus.exc_accept = ($urandom_range(0, 4) == 0);
         bus.eret       = ($urandom_range(0, 19) == 0);
         tick();
      end
      bus.we         = 1'b0;
      bus.stall      = 1'b0;
      bus.exc_accept = 1'b0;
      bus.eret       = 1'b0;
      idle(3);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
